// File: rtl/keccak_arb_pkg.sv
// Shared types and constants for the Keccak request arbiter.
package keccak_arb_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned BYTE_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        DELIVER
    } arb_state_t;

    // Pointer width for a requester index; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keccak_req_arbiter_rr_arbiter.sv
// Round-robin picker: searches from last_ptr+1 upward (wrapping) and
// returns the first requesting index as both one-hot and binary.
module rr_arbiter
    import keccak_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] last_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic             found;
    logic [PTR_W-1:0] cand;

    // First requester after last_ptr in circular order wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = PTR_W'((32'(last_ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/keccak_req_arbiter.sv
// Shares one padder + Keccak-f core between N_REQ requesters, one message
// at a time: IDLE -> CLEAR -> FEED -> WAIT -> DELIVER -> IDLE.
// Optional FEED idle watchdog enabled by defining KECCAK_ARB_TIMEOUT_EN.
module keccak_req_arbiter
    import keccak_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned D     = 512,
    parameter int unsigned TMO   = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*WORD_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*BYTE_W-1:0] req_bytes,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        dig_valid,
    input  logic [N_REQ-1:0]        dig_ack,
    output logic [D-1:0]            dig_data,
    output logic                    core_reset,
    output logic [WORD_W-1:0]       core_in,
    output logic                    core_in_ready,
    output logic                    core_is_last,
    output logic [BYTE_W-1:0]       core_byte_num,
    input  logic                    core_buf_full,
    input  logic [D-1:0]            core_out,
    input  logic                    core_out_ready,
    output logic                    err_timeout
);

    localparam int unsigned PTR_W = ptr_w(N_REQ);

    arb_state_t       state, state_nxt;
    logic [PTR_W-1:0] owner, ptr;
    logic [N_REQ-1:0] arb_grant;
    logic [PTR_W-1:0] arb_idx;
    logic             clr_pulse;
    logic             wd_expire;
    logic             wd_abort;

    logic [WORD_W-1:0] data_arr  [N_REQ];
    logic [BYTE_W-1:0] bytes_arr [N_REQ];

    logic [WORD_W-1:0] own_data;
    logic [BYTE_W-1:0] own_bytes;
    logic              own_valid;
    logic              own_last;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g]  = req_data[g*WORD_W +: WORD_W];
        assign bytes_arr[g] = req_bytes[g*BYTE_W +: BYTE_W];
    end

    assign own_data  = data_arr[owner];
    assign own_bytes = bytes_arr[owner];
    assign own_valid = req_valid[owner];
    assign own_last  = req_last[owner];

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req       (req_valid),
        .last_ptr  (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign core_reset = reset | clr_pulse | wd_abort;

`ifdef KECCAK_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TMO + 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             abort_q;
    logic             err_q;

    // Abort on the cycle that would be the TMO-th consecutive silent FEED cycle.
    assign wd_expire   = (state == FEED) && !own_valid && ((32'(idle_cnt) + 1) >= TMO);
    assign wd_abort    = abort_q;
    assign err_timeout = err_q;

    // Silent-cycle counter, one-cycle core clear after abort, sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            abort_q <= wd_expire;
            if (wd_expire) begin
                err_q <= 1'b1;
            end
            if ((state != FEED) || own_valid || wd_expire) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign wd_abort    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next-state and all handshake outputs; only the owner is ever connected.
    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        dig_valid     = '0;
        core_in       = '0;
        core_in_ready = 1'b0;
        core_is_last  = 1'b0;
        core_byte_num = '0;
        clr_pulse     = 1'b0;
        case (state)
            IDLE: begin
                if (|arb_grant) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                clr_pulse = 1'b1;
                state_nxt = FEED;
            end
            FEED: begin
                core_in          = own_data;
                core_byte_num    = own_bytes;
                core_in_ready    = own_valid;
                core_is_last     = own_valid & own_last;
                req_ready[owner] = own_valid & ~core_buf_full;
                if (own_valid && !core_buf_full && own_last) begin
                    state_nxt = WAIT;
                end
                if (wd_expire) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (core_out_ready) begin
                    state_nxt = DELIVER;
                end
            end
            DELIVER: begin
                dig_valid[owner] = 1'b1;
                if (dig_ack[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, owner latch, round-robin pointer and digest capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= PTR_W'(N_REQ - 1);
            dig_data <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && (|arb_grant)) begin
                owner <= arb_idx;
            end
            if ((state == WAIT) && core_out_ready) begin
                dig_data <= core_out;
            end
            if (((state == DELIVER) && dig_ack[owner]) || wd_expire) begin
                ptr <= owner;
            end
        end
    end

endmodule
